uart_tx_frame: RTL
==================

// Module: uart_tx_frame
// PURPOSE
//  UART transmit framer; consumes baud_trig_tx (one pulse per bit period) from the baud generator.
//  Serialises bytes LSB-first as start/data/[parity]/stop onto serial line tx.
//  One-entry holding buffer behind a valid/ready handshake allows gapless back-to-back frames.
// PARAMETERS
//  DBIT       8  data bits per frame (5..8)
//  STOP_BITS  1  stop bits per frame (1 or 2)
//  PAR_ODD    0  parity sense, used only with UART_TX_PARITY_EN: 0=even, 1=odd
// PORTS
//  clk           in   1     system clock; all state on posedge clk
//  rst           in   1     asynchronous, active-high reset
//  baud_trig_tx  in   1     1-cycle bit-period tick from baud generator
//  tx_data       in   DBIT  byte to send; sampled when tx_valid & tx_ready
//  tx_valid      in   1     producer offers tx_data
//  tx_ready      out  1     holding buffer empty (= !buf_full, registered, no bypass)
//  tx            out  1     serial line, idle high, registered
//  tx_busy       out  1     state != IDLE
//  tx_done       out  1     1-cycle pulse on the clk where final stop bit ends
// BEHAVIOUR
//  Reset (async): tx=1, tx_ready=1, tx_busy=0, tx_done=0, buffer empty, state IDLE, counters 0.
//  Handshake: accept on posedge where tx_valid & tx_ready -> buf_full=1 next cycle; tx_ready low
//   until buffer moves to shift register. Data held stable by buffer; producer may change after accept.
//  All line transitions happen only on clks with baud_trig_tx=1; tx changes the cycle after the tick.
//  FSM (enum IDLE, START, DATA, PARITY, STOP):
//   IDLE : tick & buf_full -> load shreg, clear buf, tx<=0, ->START. No tick -> wait (latency
//          accept->start edge: 1..dvsr clks).
//   START: tick -> tx<=shreg[0], bit_cnt=0, ->DATA.
//   DATA : tick -> shift right; if bit_cnt==DBIT-1 -> PARITY (if enabled) else STOP with tx<=1;
//          else bit_cnt++, tx<=next bit.
//   PARITY: tick -> tx<=1, ->STOP.
//   STOP : tick & stop_cnt==STOP_BITS-1 -> tx_done pulse; if buf_full load+tx<=0, ->START
//          (no idle gap); else ->IDLE with tx=1. Otherwise stop_cnt++.
//  Frame length = (1+DBIT+P+STOP_BITS) ticks, P=1 with parity, 0 without.
//  Simultaneous accept and load: impossible (ready=0 while full); accept during a frame is legal.
//  tx_valid without tick: buffered, frame waits for tick. Tick with empty buffer in IDLE: no effect.
//  Reset mid-frame: tx returns to 1 immediately, frame and buffered byte discarded, no tx_done.
//  Counters are sized $clog2(DBIT) / 1 bit; no wrap beyond terminal values.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA; bit = ^data ^ PAR_ODD,
//   captured at load time.
//  Not defined: PARITY state unreachable/absent; DATA -> STOP directly; PAR_ODD ignored.
// STRUCTURE
//  uart_pkg: tx_state_e enum, DBIT/STOP_BITS defaults, frame-length function.
//  Sub-module uart_tx_hold_buf: one-entry valid/ready holding register (data, full, ready).
//  Framer FSM, shift register and counters live in uart_tx_frame.
// TESTING
//  Drive baud generator dvsr=4 with this block; all cases check tx bit by bit at tick boundaries.
//  1. Reset, tx_valid=1 data=8'hA5 one cycle -> tx: 0,1,0,1,0,0,1,0,1,1; 40 clks; one tx_done.
//  2. Two bytes 8'h00, 8'hFF offered back-to-back -> 2nd accepted mid-frame; stop bit of frame 1
//     followed directly by start bit of frame 2; tx_ready low for the buffered interval only.
//  3. tx_valid held while tx_ready=0 -> no accept until buffer drained; no byte lost or duplicated.
//  4. Assert rst during DATA bit 3 of 8'h3C -> tx=1 same cycle, tx_busy=0, no tx_done, next
//     frame after reset clean.
//  5. UART_TX_PARITY_EN, PAR_ODD=0, data 8'h07 -> parity bit 1; PAR_ODD=1 -> 0; frame 11 ticks.
//  6. STOP_BITS=2, data 8'h55 -> two high stop ticks before tx_done; frame 44 clks at dvsr=4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int DBIT_DEF      = 8;
  localparam int STOP_BITS_DEF = 1;

  // Number of bit periods (baud ticks) one frame occupies on the line.
  function automatic int frame_ticks(input int dbit, input int par_bits, input int stop_bits);
    return 1 + dbit + par_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_hold_buf.sv
// One-entry holding register between the byte producer and the transmit framer.
// Accepts a word on a valid/ready handshake and keeps it until the framer loads it.
module uart_tx_hold_buf
  import uart_pkg::*;
#(
  parameter int W = DBIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         load,
  output logic [W-1:0] out_data,
  output logic         full
);

  logic         full_q, full_d;
  logic         ready_q, ready_d;
  logic [W-1:0] data_q, data_d;
  logic         accept;

  // Accept only while empty; a load can only happen while full, so the two never coincide.
  always_comb begin
    accept  = in_valid & ready_q;
    full_d  = full_q;
    data_d  = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (load) begin
      full_d = 1'b0;
    end
    ready_d = ~full_d;
  end

  // Occupancy flags; ready is kept as its own flop so the port is driven straight from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
    end
  end

  // Stored word; meaningless while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign in_ready = ready_q;
  assign out_data = data_q;
  assign full     = full_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DBIT data bits LSB first, optional parity, STOP_BITS stop bits.
// Every line transition is paced by baud_trig_tx; tx changes the clock after each tick.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit (^data ^ PAR_ODD) after the data.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DBIT      = DBIT_DEF,
  parameter int STOP_BITS = STOP_BITS_DEF,
  parameter int PAR_ODD   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            baud_trig_tx,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int CW = $clog2(DBIT);

  // Reject configurations the framer is not built for.
  if (DBIT < 5 || DBIT > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PAR_ODD < 0 || PAR_ODD > 1)
  begin : g_bad_cfg
    $error("uart_tx_frame: unsupported DBIT/STOP_BITS/PAR_ODD combination");
  end

  tx_state_e       state_q, state_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;
  logic            buf_full;
  logic [DBIT-1:0] buf_data;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  uart_tx_hold_buf #(.W(DBIT)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (tx_data),
    .in_valid (tx_valid),
    .in_ready (tx_ready),
    .load     (load),
    .out_data (buf_data),
    .full     (buf_full)
  );

  // Next-state and next-output logic; a load pulls the buffered byte into the shift register.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (baud_trig_tx && buf_full) begin
          load    = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_trig_tx) begin
          tx_d      = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_trig_tx) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == CW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_trig_tx) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_trig_tx) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d     = 1'b1;
            stop_cnt_d = 1'b0;
            // A waiting byte starts immediately so consecutive frames have no idle gap.
            if (buf_full) begin
              load    = 1'b1;
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shreg_d = buf_data;
`ifdef UART_TX_PARITY_EN
      par_d   = (^buf_data) ^ 1'(PAR_ODD);
`endif
    end
    busy_d = (state_d != IDLE);
  end

  // Framer FSM, counters and registered line outputs; reset returns the line to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Shift register (and parity bit) only carry data, always reloaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
